upscale_x2: RTL

//  2x nearest-neighbour upscaler, the inverse of the 2x2 binning filter: input
//  X*Y -> output 2X*2Y. Each input pixel is emitted twice per line; each line twice.

---
 rtl/upscale_x2.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/upscale_x2.sv
// upscale_x2: 2x nearest-neighbour upscaler using ping-pong line banks.
// Each committed input line is replayed twice, each pixel emitted twice.
module upscale_x2 #(
    parameter int LINE_SIZE_MAX = 1024,
    parameter int DATA_WIDTH    = 8,
    parameter int HBLANK        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bypass,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  ovf_o
);
    localparam int AW = $clog2(LINE_SIZE_MAX);
    localparam int PW = $clog2(LINE_SIZE_MAX + 1);
    localparam int CW = $clog2(2 * LINE_SIZE_MAX + HBLANK + 1);

    typedef enum logic [2:0] {IDLE, L0, G0, L1, G1} state_t;

    state_t                state_q, state_d;
    logic                  hs_q, vs_q, act_q, ovf_q, ovf_d;
    logic                  wact_q, wact_d, wbank_q, wbank_d, bsel_q, bsel_d;
    logic                  rsel_q, rsel_d, cur_q, cur_d;
    logic [1:0]            full_q, full_d, fullc;
    logic [PW-1:0]         wptr_q, wptr_d, wptr_e;
    logic [PW-1:0]         len_q [2];
    logic [CW-1:0]         cnt_q, cnt_d, len2;
    logic [AW:0]           waddr, raddr;
    logic [DATA_WIDTH-1:0] mem [2*LINE_SIZE_MAX];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  hs_rise, hs_fall, vs_rise, bselc, we, commit, rel;

    assign hs_rise = hs_i & ~hs_q;
    assign hs_fall = ~hs_i & hs_q;
    assign vs_rise = vs_i & ~vs_q;
    // A new frame discards any pending lines before the write side looks for a bank
    assign fullc   = vs_rise ? 2'b00 : full_q;
    assign bselc   = vs_rise ? 1'b0 : bsel_q;
    assign wact_d  = hs_rise ? ~fullc[bselc] & ~bypass : wact_q & ~hs_fall;
    assign wbank_d = hs_rise ? bselc : wbank_q;
    assign wptr_e  = hs_rise ? '0 : wptr_q;
    assign we      = de_i & hs_i & wact_d & (wptr_e < PW'(LINE_SIZE_MAX));
    assign wptr_d  = wptr_e + PW'(we);
    assign commit  = hs_fall & wact_q & (wptr_q != '0);
    assign ovf_d   = ovf_q | (hs_rise & fullc[bselc] & ~bypass);
    assign bsel_d  = bypass ? 1'b0 : bselc ^ commit;
    assign rsel_d  = (vs_rise | bypass) ? 1'b0 : rel ? ~cur_q : rsel_q;
    assign len2    = CW'({len_q[cur_q], 1'b0});
    assign waddr   = {wbank_d, wptr_e[AW-1:0]};
    assign raddr   = {cur_q, cnt_q[AW:1]};
    assign ovf_o   = ovf_q;

    always_comb begin
        full_d = fullc;
        if (rel) full_d[cur_q] = 1'b0;
        if (commit) full_d[wbank_q] = 1'b1;
        if (bypass) full_d = 2'b00;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        cur_d   = cur_q;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|full_q) begin
                    state_d = L0;
                    cur_d   = full_q[rsel_q] ? rsel_q : ~rsel_q;
                end
            end
            L0, L1: if (cnt_q == len2 - CW'(1)) begin
                state_d = (state_q == L0) ? G0 : G1;
                cnt_d   = '0;
            end
            G0: if (cnt_q == CW'(HBLANK - 1)) begin
                state_d = L1;
                cnt_d   = '0;
            end
            G1: if (cnt_q == CW'(HBLANK - 1)) begin
                rel     = 1'b1;
                cnt_d   = '0;
                cur_d   = ~cur_q;
                state_d = full_q[~cur_q] ? L0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bypass) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= di_i;
        rdata_q <= mem[raddr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            act_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wact_q   <= 1'b0;
            wbank_q  <= 1'b0;
            bsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            cur_q    <= 1'b0;
            full_q   <= 2'b00;
            wptr_q   <= '0;
            len_q[0] <= '0;
            len_q[1] <= '0;
            cnt_q    <= '0;
            do_o     <= '0;
            de_o     <= 1'b0;
            hs_o     <= 1'b0;
            vs_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_i;
            vs_q    <= vs_i;
            ovf_q   <= ovf_d;
            wact_q  <= wact_d;
            wbank_q <= wbank_d;
            bsel_q  <= bsel_d;
            rsel_q  <= rsel_d;
            cur_q   <= cur_d;
            full_q  <= full_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            if (commit) len_q[wbank_q] <= wptr_q;
            // act_q lines the control up with the one-cycle RAM read
            act_q   <= (state_q == L0 || state_q == L1) & ~bypass;
            if (bypass) begin
                do_o <= di_i;
                de_o <= de_i;
                hs_o <= hs_i;
                vs_o <= vs_i;
            end else begin
                if (act_q) do_o <= rdata_q;
                de_o <= act_q;
                hs_o <= act_q;
                vs_o <= vs_i | (state_q != IDLE);
            end
        end
    end
endmodule
